// File: rtl/nios_system_pio_pkg.sv
// Shared register map and STATUS layout for the blinking PIO output peripheral.
package nios_system_pio_pkg;

  localparam logic [2:0] ADDR_DATA      = 3'd0;
  localparam logic [2:0] ADDR_BLINK_EN  = 3'd1;
  localparam logic [2:0] ADDR_PERIOD    = 3'd2;
  localparam logic [2:0] ADDR_STATUS    = 3'd3;
  localparam logic [2:0] ADDR_OUTSET    = 3'd4;
  localparam logic [2:0] ADDR_OUTCLEAR  = 3'd5;
  localparam logic [2:0] ADDR_OUTTOGGLE = 3'd6;

  localparam int STATUS_PHASE_BIT = 0;

  function automatic logic [31:0] status_word(input logic phase);
    logic [31:0] w;
    w = '0;
    w[STATUS_PHASE_BIT] = phase;
    return w;
  endfunction

endpackage

// File: rtl/nios_system_pio_blink_timer.sv
// Half-period timer: phase inverts every period+1 cycles; a period load restarts the count.
module nios_system_pio_blink_timer
  import nios_system_pio_pkg::*;
#(
  parameter int PERIOD_WIDTH = 24
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic [PERIOD_WIDTH-1:0] period,
  input  logic                    period_load,
  output logic                    phase
);

  localparam logic [PERIOD_WIDTH-1:0] ONE = PERIOD_WIDTH'(1);

  logic [PERIOD_WIDTH-1:0] count_p0;

  // A load in the terminal-count cycle wins: the count restarts and phase holds.
  always_ff @(posedge clk) begin
    if (reset) begin
      count_p0 <= '0;
      phase    <= 1'b1;
    end else if (period_load) begin
      count_p0 <= '0;
    end else if (count_p0 == period) begin
      count_p0 <= '0;
      phase    <= ~phase;
    end else begin
      count_p0 <= count_p0 + ONE;
    end
  end

endmodule

// File: rtl/nios_system_pio_out_blink.sv
// Avalon-MM PIO output with per-channel blink gating, atomic set/clear/toggle and 1-cycle reads.
module nios_system_pio_out_blink
  import nios_system_pio_pkg::*;
#(
  parameter int          DATA_WIDTH   = 10,
  parameter logic [31:0] RESET_VALUE  = 32'd0,
  parameter int          PERIOD_WIDTH = 24,
  parameter logic [31:0] RESET_PERIOD = 32'd12_499_999
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [2:0]            address,
  input  logic                  chipselect,
  input  logic                  write_n,
  input  logic                  read_n,
  input  logic [31:0]           writedata,
  output logic [31:0]           readdata,
  output logic                  readdatavalid,
  output logic [DATA_WIDTH-1:0] out_port
);

  localparam logic [DATA_WIDTH-1:0]   DATA_RST   = RESET_VALUE[DATA_WIDTH-1:0];
  localparam logic [PERIOD_WIDTH-1:0] PERIOD_RST = RESET_PERIOD[PERIOD_WIDTH-1:0];

  logic                    wr_en;
  logic                    rd_en;
  logic [DATA_WIDTH-1:0]   wr_data;
  logic [DATA_WIDTH-1:0]   data_p0;
  logic [DATA_WIDTH-1:0]   blink_en_p0;
  logic [PERIOD_WIDTH-1:0] period_p0;
  logic                    period_load;
  logic                    phase;
  logic [31:0]             rd_mux;
  logic                    unused_wdata;

  assign wr_en        = chipselect & ~write_n;
  assign rd_en        = chipselect & ~read_n;
  assign wr_data      = writedata[DATA_WIDTH-1:0];
  assign period_load  = wr_en & (address == ADDR_PERIOD);
  assign unused_wdata = ^writedata;

  // Stage p0: register file.
  always_ff @(posedge clk) begin
    if (reset) begin
      data_p0     <= DATA_RST;
      blink_en_p0 <= '0;
      period_p0   <= PERIOD_RST;
    end else if (wr_en) begin
      case (address)
        ADDR_DATA:      data_p0     <= wr_data;
        ADDR_BLINK_EN:  blink_en_p0 <= wr_data;
        ADDR_PERIOD:    period_p0   <= writedata[PERIOD_WIDTH-1:0];
        ADDR_OUTSET:    data_p0     <= data_p0 | wr_data;
        ADDR_OUTCLEAR:  data_p0     <= data_p0 & ~wr_data;
        ADDR_OUTTOGGLE: data_p0     <= data_p0 ^ wr_data;
        default: ;
      endcase
    end
  end

  nios_system_pio_blink_timer #(
    .PERIOD_WIDTH(PERIOD_WIDTH)
  ) u_blink_timer (
    .clk        (clk),
    .reset      (reset),
    .period     (period_p0),
    .period_load(period_load),
    .phase      (phase)
  );

  // Read mux sees pre-write register values, so a colliding read returns old data.
  always_comb begin
    rd_mux = '0;
    case (address)
      ADDR_DATA:     rd_mux[DATA_WIDTH-1:0]   = data_p0;
      ADDR_BLINK_EN: rd_mux[DATA_WIDTH-1:0]   = blink_en_p0;
      ADDR_PERIOD:   rd_mux[PERIOD_WIDTH-1:0] = period_p0;
      ADDR_STATUS:   rd_mux                   = status_word(phase);
      default: ;
    endcase
  end

  // Stage p1: registered outputs and read response.
  always_ff @(posedge clk) begin
    if (reset) begin
      out_port      <= DATA_RST;
      readdata      <= '0;
      readdatavalid <= 1'b0;
    end else begin
      out_port      <= data_p0 & (~blink_en_p0 | {DATA_WIDTH{phase}});
      readdata      <= rd_en ? rd_mux : '0;
      readdatavalid <= rd_en;
    end
  end

endmodule

// File: tb/tb_nios_system_pio_out_blink.sv
// Scenario bench for the blinking PIO: read responses are scoreboarded through a queue.
module tb_nios_system_pio_out_blink;
  import nios_system_pio_pkg::*;

  localparam logic [9:0]  RV = 10'h2A5;
  localparam logic [31:0] RP = 32'h00BE_BC1F;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [2:0]  address = '0;
  logic        chipselect = 1'b0;
  logic        write_n = 1'b1;
  logic        read_n = 1'b1;
  logic [31:0] writedata = '0;
  logic [31:0] readdata;
  logic        readdatavalid;
  logic [9:0]  out_port;

  int vectors = 0;
  int miscompares = 0;
  logic [31:0] exp_q[$];

  always #5 clk = ~clk;

  nios_system_pio_out_blink #(
    .DATA_WIDTH  (10),
    .RESET_VALUE (32'h2A5),
    .PERIOD_WIDTH(24),
    .RESET_PERIOD(32'd12_499_999)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .address      (address),
    .chipselect   (chipselect),
    .write_n      (write_n),
    .read_n       (read_n),
    .writedata    (writedata),
    .readdata     (readdata),
    .readdatavalid(readdatavalid),
    .out_port     (out_port)
  );

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic bus_write(input logic [2:0] a, input logic [31:0] d);
    chipselect = 1'b1; write_n = 1'b0; address = a; writedata = d;
    @(negedge clk);
    chipselect = 1'b0; write_n = 1'b1; writedata = '0;
  endtask

  task automatic test_reset();
    logic [31:0] exp_tab [8];
    logic [31:0] e;
    reset = 1'b1;
    repeat (3) @(negedge clk);
    vectors++;
    if (out_port !== RV) begin
      miscompares++; $display("FAIL reset_out_port got %h want %h", out_port, RV);
    end
    vectors++;
    if ({readdatavalid, readdata} !== 33'd0) begin
      miscompares++; $display("FAIL reset_rd got rdv=%b data=%h want 0/0", readdatavalid, readdata);
    end
    reset = 1'b0;
    @(negedge clk);
    vectors++;
    if (out_port !== RV) begin
      miscompares++; $display("FAIL post_reset_out_port got %h want %h", out_port, RV);
    end
    exp_tab = '{32'h2A5, 32'h0, RP, 32'h1, 32'h0, 32'h0, 32'h0, 32'h0};
    chipselect = 1'b1; read_n = 1'b0;
    for (int i = 0; i < 8; i++) begin
      address = 3'(i);
      exp_q.push_back(exp_tab[i]);
      @(negedge clk);
      e = exp_q.pop_front();
      vectors++;
      if ({readdatavalid, readdata} !== {1'b1, e}) begin
        miscompares++;
        $display("FAIL reset_read addr=%0d got rdv=%b data=%h want 1/%h", i, readdatavalid, readdata, e);
      end
    end
    chipselect = 1'b0; read_n = 1'b1;
    @(negedge clk);
    vectors++;
    if ({readdatavalid, readdata} !== 33'd0) begin
      miscompares++; $display("FAIL read_idle got rdv=%b data=%h want 0/0", readdatavalid, readdata);
    end
  endtask

  task automatic test_set_clear();
    logic [31:0] e;
    bus_write(ADDR_DATA, 32'h0F0);
    bus_write(ADDR_OUTSET, 32'h003);
    bus_write(ADDR_OUTCLEAR, 32'h030);
    bus_write(ADDR_OUTTOGGLE, 32'h300);
    bus_write(ADDR_STATUS, 32'hFFFF_FFFF);
    bus_write(3'd7, 32'hFFFF_FFFF);
    bus_write(ADDR_OUTSET, 32'hFFFF_FC00);
    bus_write(ADDR_BLINK_EN, 32'hFFFF_FC00);
    chipselect = 1'b1; read_n = 1'b0; address = ADDR_DATA;
    exp_q.push_back(32'h3C3);
    @(negedge clk);
    address = ADDR_BLINK_EN;
    exp_q.push_back(32'h0);
    e = exp_q.pop_front();
    vectors++;
    if ({readdatavalid, readdata} !== {1'b1, e}) begin
      miscompares++; $display("FAIL setclr_data got rdv=%b data=%h want 1/%h", readdatavalid, readdata, e);
    end
    vectors++;
    if (out_port !== 10'h3C3) begin
      miscompares++; $display("FAIL setclr_out_port got %h want 3c3", out_port);
    end
    @(negedge clk);
    chipselect = 1'b0; read_n = 1'b1;
    e = exp_q.pop_front();
    vectors++;
    if ({readdatavalid, readdata} !== {1'b1, e}) begin
      miscompares++; $display("FAIL setclr_blink_en got rdv=%b data=%h want 1/%h", readdatavalid, readdata, e);
    end
  endtask

  task automatic test_collision();
    logic [31:0] e;
    chipselect = 1'b1; read_n = 1'b0; write_n = 1'b0;
    address = ADDR_DATA; writedata = 32'hFFFF_FD55;
    exp_q.push_back(32'h3C3);
    @(negedge clk);
    write_n = 1'b1; writedata = '0;
    e = exp_q.pop_front();
    vectors++;
    if ({readdatavalid, readdata} !== {1'b1, e}) begin
      miscompares++; $display("FAIL collision_old got rdv=%b data=%h want 1/%h", readdatavalid, readdata, e);
    end
    exp_q.push_back(32'h155);
    @(negedge clk);
    chipselect = 1'b0; read_n = 1'b1;
    e = exp_q.pop_front();
    vectors++;
    if ({readdatavalid, readdata} !== {1'b1, e}) begin
      miscompares++; $display("FAIL collision_new got rdv=%b data=%h want 1/%h", readdatavalid, readdata, e);
    end
    vectors++;
    if (out_port !== 10'h155) begin
      miscompares++; $display("FAIL collision_out_port got %h want 155", out_port);
    end
  endtask

  task automatic test_blink_period3();
    logic prev;
    logic v;
    logic b;
    logic found;
    bus_write(ADDR_PERIOD, 32'd3);
    bus_write(ADDR_BLINK_EN, 32'h001);
    bus_write(ADDR_DATA, 32'h001);
    @(negedge clk);
    prev = out_port[0];
    found = 1'b0;
    for (int i = 0; i < 12 && !found; i++) begin
      @(negedge clk);
      if (out_port[0] !== prev) found = 1'b1;
    end
    vectors++;
    if (!found) begin
      miscompares++; $display("FAIL blink3_edge got no edge in 12 cycles want edge");
    end
    v = out_port[0];
    for (int k = 1; k < 16; k++) begin
      @(negedge clk);
      b = ((k / 4) % 2 != 0) ? ~v : v;
      vectors++;
      if (out_port !== {9'b0, b}) begin
        miscompares++; $display("FAIL blink3 cycle=%0d got %h want %h", k, out_port, {9'b0, b});
      end
    end
  endtask

  task automatic test_period0();
    logic [9:0]  prev;
    logic [31:0] e;
    bus_write(ADDR_PERIOD, 32'd0);
    bus_write(ADDR_BLINK_EN, 32'h3FF);
    bus_write(ADDR_DATA, 32'h3FF);
    repeat (2) @(negedge clk);
    prev = out_port;
    vectors++;
    if (prev !== 10'h3FF && prev !== 10'h000) begin
      miscompares++; $display("FAIL period0_level got %h want 3ff or 000", prev);
    end
    chipselect = 1'b1; read_n = 1'b0; address = ADDR_STATUS;
    exp_q.push_back({31'b0, ~out_port[0]});
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      e = exp_q.pop_front();
      vectors++;
      if ({readdatavalid, readdata} !== {1'b1, e}) begin
        miscompares++; $display("FAIL period0_status i=%0d got rdv=%b data=%h want 1/%h", i, readdatavalid, readdata, e);
      end
      vectors++;
      if (out_port !== ~prev) begin
        miscompares++; $display("FAIL period0_toggle i=%0d got %h want %h", i, out_port, ~prev);
      end
      prev = out_port;
      if (i < 9) exp_q.push_back({31'b0, ~out_port[0]});
      else begin
        chipselect = 1'b0; read_n = 1'b1;
      end
    end
  endtask

  task automatic test_period_reload();
    logic       ref_ph;
    logic [9:0] expv;
    bus_write(ADDR_BLINK_EN, 32'h001);
    bus_write(ADDR_DATA, 32'h001);
    @(negedge clk);
    bus_write(ADDR_PERIOD, 32'd5);
    ref_ph = out_port[0];
    for (int k = 1; k < 20; k++) begin
      if (k == 6) bus_write(ADDR_PERIOD, 32'd5);
      else @(negedge clk);
      expv = {9'b0, (k <= 12) ? ref_ph : ((k <= 18) ? ~ref_ph : ref_ph)};
      vectors++;
      if (out_port !== expv) begin
        miscompares++; $display("FAIL reload cycle=%0d got %h want %h", k, out_port, expv);
      end
    end
  endtask

  task automatic test_reset_during_reads();
    logic [31:0] exp_tab [4];
    logic [31:0] e;
    bus_write(ADDR_PERIOD, 32'd0);
    chipselect = 1'b1; read_n = 1'b0; address = ADDR_DATA;
    exp_q.push_back(32'h001);
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      e = exp_q.pop_front();
      vectors++;
      if ({readdatavalid, readdata} !== {1'b1, e}) begin
        miscompares++; $display("FAIL b2b_read i=%0d got rdv=%b data=%h want 1/%h", i, readdatavalid, readdata, e);
      end
      if (i < 3) exp_q.push_back(32'h001);
      else reset = 1'b1;
    end
    @(negedge clk);
    vectors++;
    if ({readdatavalid, readdata} !== 33'd0) begin
      miscompares++; $display("FAIL reset_kills_read got rdv=%b data=%h want 0/0", readdatavalid, readdata);
    end
    vectors++;
    if (out_port !== RV) begin
      miscompares++; $display("FAIL rst2_out_port got %h want %h", out_port, RV);
    end
    chipselect = 1'b0; read_n = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    exp_tab = '{32'h2A5, 32'h0, RP, 32'h1};
    chipselect = 1'b1; read_n = 1'b0;
    for (int i = 0; i < 4; i++) begin
      address = 3'(i);
      exp_q.push_back(exp_tab[i]);
      @(negedge clk);
      e = exp_q.pop_front();
      vectors++;
      if ({readdatavalid, readdata} !== {1'b1, e}) begin
        miscompares++; $display("FAIL rst2_read addr=%0d got rdv=%b data=%h want 1/%h", i, readdatavalid, readdata, e);
      end
    end
    chipselect = 1'b0; read_n = 1'b1;
    vectors++;
    if (out_port !== RV) begin
      miscompares++; $display("FAIL rst2_out_port_hold got %h want %h", out_port, RV);
    end
    vectors++;
    if (exp_q.size() != 0) begin
      miscompares++; $display("FAIL scoreboard_drain got %0d pending want 0", exp_q.size());
    end
  endtask

  initial begin
    test_reset();
    test_set_clear();
    test_collision();
    test_blink_period3();
    test_period0();
    test_period_reload();
    test_reset_during_reads();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/nios_system_pio_out_blink.md
NIOS_SYSTEM_PIO_OUT_BLINK -- requirements
Module: nios_system_pio_out_blink

Interface
REQ-001 Parameter DATA_WIDTH, default 10, number of output channels (1..32).
REQ-002 Parameter RESET_VALUE, default 0, DATA register value after reset.
REQ-003 Parameter PERIOD_WIDTH, default 24, width of the blink half-period register (1..32).
REQ-004 Parameter RESET_PERIOD, default 24'd12_499_999, PERIOD register value after reset (0.25 s half-period at 50 MHz).
REQ-005 Port clk input 1: single system clock, all logic on the rising edge.
REQ-006 Port reset input 1: synchronous, active-high reset.
REQ-007 Port address input 3: Avalon-MM word offset.
REQ-008 Port chipselect input 1: slave select.
REQ-009 Port write_n input 1: active-low write strobe, qualified by chipselect.
REQ-010 Port read_n input 1: active-low read strobe, qualified by chipselect.
REQ-011 Port writedata input 32: write data.
REQ-012 Port readdata output 32: registered read data.
REQ-013 Port readdatavalid output 1: one-cycle pulse marking valid readdata.
REQ-014 Port out_port output DATA_WIDTH: channel outputs.

Function
REQ-015 Register map: 0 DATA rw; 1 BLINK_EN rw; 2 PERIOD rw; 3 STATUS ro; 4 OUTSET wo; 5 OUTCLEAR wo; 6 OUTTOGGLE wo; 7 reserved.
REQ-016 Write = chipselect & ~write_n; read = chipselect & ~read_n; a simultaneous read and write to the same offset returns the pre-write value.
REQ-017 DATA write: DATA <= writedata[DATA_WIDTH-1:0].
REQ-018 OUTSET write: DATA <= DATA | writedata[DATA_WIDTH-1:0].
REQ-019 OUTCLEAR write: DATA <= DATA & ~writedata[DATA_WIDTH-1:0].
REQ-020 OUTTOGGLE write: DATA <= DATA ^ writedata[DATA_WIDTH-1:0].
REQ-021 BLINK_EN write: BLINK_EN <= writedata[DATA_WIDTH-1:0].
REQ-022 PERIOD write: PERIOD <= writedata[PERIOD_WIDTH-1:0], counter <= 0; phase is unchanged.
REQ-023 Blink timer: the counter increments each cycle; when counter == PERIOD it returns to 0 and phase inverts, so the phase half-period is PERIOD+1 cycles.
REQ-024 PERIOD = 0: phase inverts every cycle.
REQ-025 A PERIOD write in the cycle the counter reaches terminal count: the write wins, so counter = 0 and phase does not invert.
REQ-026 out_port = DATA & (~BLINK_EN | {DATA_WIDTH{phase}}), registered; it updates one cycle after the DATA, BLINK_EN or phase change.
REQ-027 Read latency is exactly 1: readdatavalid = 1 and readdata are valid in the cycle after the read strobe; otherwise readdatavalid = 0 and readdata = 0.
REQ-028 Read values: DATA, BLINK_EN and PERIOD are zero-extended to 32 bits; STATUS = {31'b0, phase}; offsets 4-7 read 0.
REQ-029 Writes to STATUS or offset 7 are ignored; unused writedata bits are ignored.
REQ-030 A read strobe held for N consecutive cycles yields N consecutive valid responses.

Reset
REQ-031 On reset: DATA = RESET_VALUE, BLINK_EN = 0, PERIOD = RESET_PERIOD, counter = 0, phase = 1, out_port = RESET_VALUE, readdata = 0, readdatavalid = 0.
REQ-032 Reset overrides any write or read in the same cycle; a read pending at reset produces no readdatavalid.

Structure
REQ-033 Package nios_system_pio_pkg holds the register offset constants (ADDR_DATA .. ADDR_OUTTOGGLE) and the STATUS bit index.
REQ-034 The blink counter and phase live in sub-module nios_system_pio_blink_timer, with ports clk, reset, period, period_load, phase.

Verification
REQ-035 Reset with RESET_VALUE = 10'h2A5 -> out_port = 10'h2A5, then a read of offset 0 returns 32'h2A5 with readdatavalid one cycle after the strobe.
REQ-036 Write DATA = 0x0F0, then OUTSET = 0x003, OUTCLEAR = 0x030, OUTTOGGLE = 0x300 -> DATA reads back 0x3C3 and out_port = 0x3C3.
REQ-037 PERIOD = 3, BLINK_EN = 0x001, DATA = 0x001 -> out_port[0] toggles every 4 cycles and out_port[9:1] stays 0.
REQ-038 PERIOD = 0 with BLINK_EN = 0x3FF and DATA = 0x3FF -> out_port alternates 0x3FF / 0x000 every cycle, and STATUS bit 0 tracks phase.
REQ-039 PERIOD = 5, then rewrite PERIOD = 5 in the cycle the counter equals 5 -> no phase inversion that cycle, and the next inversion follows 6 cycles later.
REQ-040 Assert reset during back-to-back reads with blink active -> readdatavalid = 0 the following cycle and all REQ-031 values are restored.
